// File: rtl/hls_deadlock_watchdog_ctrl_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock watchdog.
package hls_wdog_pkg;

    // Watchdog FSM states; the encoding is visible on state_o for debug.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_SUSPECT = 3'd2,
        ST_REPORT  = 3'd3,
        ST_LATCHED = 3'd4
    } wdog_state_t;

    // Consecutive blocked cycles that declare a deadlock when not overridden.
    localparam int DEFAULT_TIMEOUT = 1024;

    // Widest block vector the index helper accepts.
    localparam int MAX_VEC_W = 32;

    // Index of the lowest set bit; returns 0 for an all-zero vector.
    function automatic int unsigned lowest_set_idx(input logic [MAX_VEC_W-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_VEC_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hls_deadlock_watchdog_ctrl_if.sv
// Deadlock report channel between the watchdog and its consumer.
//
// Handshake: rpt_valid rises together with a complete, stable report and
// stays high, with every rpt_* field held, until a rising edge samples
// rpt_valid & rpt_ready; that edge is the transfer. The consumer may hold
// rpt_ready high ahead of time.
interface hls_deadlock_watchdog_ctrl_if #(
    parameter int NUM_PROC = 5,
    parameter int CNT_W    = 16,
    parameter int IDX_W    = 3
);
    logic                rpt_valid;
    logic                rpt_ready;
    logic [NUM_PROC-1:0] rpt_mask;
    logic [IDX_W-1:0]    rpt_first_idx;
    logic [CNT_W-1:0]    rpt_cycles;

    modport master (
        output rpt_valid,
        output rpt_mask,
        output rpt_first_idx,
        output rpt_cycles,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_mask,
        input  rpt_first_idx,
        input  rpt_cycles,
        output rpt_ready
    );
endinterface

// File: rtl/hls_deadlock_watchdog_ctrl_prio_enc.sv
// Lowest-index priority encoder: reports which process is blocked first.
module hls_wdog_prio_enc
    import hls_wdog_pkg::*;
#(
    parameter int NUM_PROC = 5,
    parameter int IDX_W    = 3
) (
    input  logic [NUM_PROC-1:0] vec,
    output logic [IDX_W-1:0]    idx,
    output logic                valid
);
    logic [MAX_VEC_W-1:0] vec_ext;

    // Zero-extend the block vector to the helper's fixed width.
    always_comb begin
        vec_ext = '0;
        vec_ext[NUM_PROC-1:0] = vec;
    end

    assign idx   = IDX_W'(lowest_set_idx(vec_ext));
    assign valid = |vec;
endmodule

// File: rtl/hls_deadlock_watchdog_ctrl.sv
// Deadlock watchdog: arms on start, filters transient block indications
// through a consecutive-cycle timeout, then latches and delivers a report.
module hls_deadlock_watchdog_ctrl
    import hls_wdog_pkg::*;
#(
    parameter int NUM_PROC = 5,
    parameter int TIMEOUT  = DEFAULT_TIMEOUT,
    parameter int CNT_W    = 16,
    parameter int IDX_W    = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic [NUM_PROC-1:0]           proc_block,
    input  logic [NUM_PROC-1:0]           proc_idle,
    hls_deadlock_watchdog_ctrl_if.master  rpt,
    output logic                          deadlock,
    output logic [2:0]                    state_o
);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    wdog_state_t         state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [NUM_PROC-1:0] mask_q, mask_nxt;
    logic [IDX_W-1:0]    first_q, first_nxt;
    logic [CNT_W-1:0]    cycles_q, cycles_nxt;
    logic                valid_q, valid_nxt;
    logic                dl_q, dl_nxt;

    logic [NUM_PROC-1:0] eff_block;
    logic                any_block;
    logic [IDX_W-1:0]    enc_idx;
    logic                last_count;

    // An idle process is never counted as blocked.
    assign eff_block = proc_block & ~proc_idle;

    hls_wdog_prio_enc #(
        .NUM_PROC (NUM_PROC),
        .IDX_W    (IDX_W)
    ) u_prio_enc (
        .vec   (eff_block),
        .idx   (enc_idx),
        .valid (any_block)
    );

    // In SUSPECT the counter is below TIMEOUT, so the increment cannot wrap.
    assign last_count = (cnt + CNT_W'(1)) == TIMEOUT_C;

    // Next-state and next report contents; stop outranks everything but reset.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        mask_nxt   = mask_q;
        first_nxt  = first_q;
        cycles_nxt = cycles_q;
        valid_nxt  = valid_q;
        dl_nxt     = dl_q;

        if (stop) begin
            state_nxt  = ST_IDLE;
            cnt_nxt    = '0;
            mask_nxt   = '0;
            first_nxt  = '0;
            cycles_nxt = '0;
            valid_nxt  = 1'b0;
            dl_nxt     = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (any_block) begin
                        cnt_nxt   = CNT_W'(1);
                        mask_nxt  = eff_block;
                        first_nxt = enc_idx;
                        if (TIMEOUT == 1) begin
                            state_nxt  = ST_REPORT;
                            cycles_nxt = TIMEOUT_C;
                            valid_nxt  = 1'b1;
                            dl_nxt     = 1'b1;
                        end else begin
                            state_nxt = ST_SUSPECT;
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (any_block) begin
                        cnt_nxt  = cnt + CNT_W'(1);
                        mask_nxt = mask_q | eff_block;
                        if (last_count) begin
                            state_nxt  = ST_REPORT;
                            cycles_nxt = TIMEOUT_C;
                            valid_nxt  = 1'b1;
                            dl_nxt     = 1'b1;
                        end
                    end else begin
                        state_nxt = ST_ARMED;
                        cnt_nxt   = '0;
                        mask_nxt  = '0;
                        first_nxt = '0;
                    end
                end
                ST_REPORT: begin
                    if (rpt.rpt_ready) begin
                        state_nxt = ST_LATCHED;
                        valid_nxt = 1'b0;
                    end
                end
                ST_LATCHED: begin
                    state_nxt = ST_LATCHED;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter and registered report fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            mask_q   <= '0;
            first_q  <= '0;
            cycles_q <= '0;
            valid_q  <= 1'b0;
            dl_q     <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            mask_q   <= mask_nxt;
            first_q  <= first_nxt;
            cycles_q <= cycles_nxt;
            valid_q  <= valid_nxt;
            dl_q     <= dl_nxt;
        end
    end

    assign rpt.rpt_valid     = valid_q;
    assign rpt.rpt_mask      = mask_q;
    assign rpt.rpt_first_idx = first_q;
    assign rpt.rpt_cycles    = cycles_q;
    assign deadlock          = dl_q;
    assign state_o           = 3'(state);
endmodule

// File: doc/hls_deadlock_watchdog_ctrl.md
Name: hls_deadlock_watchdog_ctrl

Overview:
- Supervises the per-process deadlock monitors of an HLS dataflow region, e.g. the extractEFrames_accel AXIVideo2BayerMat/Bayer pipeline.
- Arms on software/testbench start and filters transient block indications through a consecutive-cycle timeout.
- On timeout, latches a deadlock report (which processes blocked, which one blocked first, how long) and delivers it over a valid/ready handshake.
- Sits beside the simulation deadlock monitors; its outputs go to the sim harness and an optional status register.

Parameters:
- NUM_PROC, 5, number of supervised processes / monitor block inputs.
- TIMEOUT, 1024, consecutive blocked cycles that declare a deadlock; legal range 1 .. 2^CNT_W-1.
- CNT_W, 16, width of the blocked-cycle counter.
- IDX_W, 3, width of the process index; must satisfy 2^IDX_W >= NUM_PROC.

Ports:
- clock  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; arms the watchdog.
- stop  in  1  single-cycle pulse; disarms and clears the watchdog from any state.
- proc_block  in  NUM_PROC  per-process block flag from the monitors.
- proc_idle  in  NUM_PROC  per-process idle flag; an idle process is never counted as blocked.
- rpt_valid  out  1  deadlock report valid.
- rpt_ready  in  1  report consumer ready.
- rpt_mask  out  NUM_PROC  OR of all effective block vectors over the suspect window.
- rpt_first_idx  out  IDX_W  lowest-index process blocked in the first suspect cycle.
- rpt_cycles  out  CNT_W  blocked-cycle count at declaration; equals TIMEOUT.
- deadlock  out  1  sticky deadlock flag.
- state_o  out  3  current FSM state encoding, for debug.

Behaviour:
- Definitions:
  - eff_block = proc_block & ~proc_idle.
  - any_block = |eff_block.
- Reset:
  - State goes to IDLE.
  - rpt_valid, deadlock, rpt_mask, rpt_first_idx, rpt_cycles and the counter all go to 0.
  - state_o = IDLE.
  - Reset overrides every other input in the same cycle.
- FSM states (encoding 0..4): IDLE, ARMED, SUSPECT, REPORT, LATCHED.
- IDLE:
  - Inputs are ignored.
  - start & ~stop -> ARMED.
  - start and stop asserted together -> stop wins; stay in IDLE.
- ARMED:
  - any_block -> SUSPECT.
  - On that transition: counter = 1, rpt_mask = eff_block, rpt_first_idx = lowest set bit of eff_block.
- SUSPECT:
  - any_block -> counter +1; rpt_mask |= eff_block.
  - ~any_block -> ARMED; counter, rpt_mask and rpt_first_idx cleared to 0.
  - Declaration occurs when the counter would reach TIMEOUT on this cycle's update:
    - go to REPORT;
    - rpt_cycles = TIMEOUT, rpt_valid = 1, deadlock = 1.
    - The counter never exceeds TIMEOUT, so it cannot wrap.
  - Timing: any_block sampled high on TIMEOUT consecutive edges starting from ARMED gives rpt_valid = 1 immediately after the TIMEOUT-th edge.
  - TIMEOUT = 1: declaration happens on the ARMED -> SUSPECT edge; go directly ARMED -> REPORT.
- REPORT:
  - rpt_valid is held and all rpt_* fields are held stable until rpt_valid & rpt_ready; then go to LATCHED with rpt_valid = 0.
  - rpt_ready already high on the entry cycle -> handshake completes on the next edge.
- LATCHED:
  - deadlock stays 1; rpt_* fields hold their values.
  - Block inputs are ignored.
  - start is ignored.
- stop in ARMED, SUSPECT, REPORT or LATCHED -> IDLE on the next edge.
  - Clears rpt_valid, deadlock, the counter and all rpt_* fields.
  - A pending report is dropped without a handshake.
- Mid-operation: stop has priority over declaration in the same cycle.
- rpt_* fields are registered outputs; there is no combinational path from input to output.

Decomposition:
- Package hls_wdog_pkg:
  - the state enum (IDLE=0, ARMED=1, SUSPECT=2, REPORT=3, LATCHED=4);
  - a default-TIMEOUT constant;
  - a lowest-set-bit index function.
- One sub-module, hls_wdog_prio_enc: parameterised NUM_PROC -> IDX_W lowest-index priority encoder with a valid output.
  - Purely combinational.
  - Reused by the report capture.

Test Plan (bench overrides: TIMEOUT=8, NUM_PROC=5):
- Reset then start; hold proc_block=5'b00100, idle=0 for 8 cycles -> rpt_valid=1 after the 8th edge; rpt_mask=00100, rpt_first_idx=2, rpt_cycles=8, deadlock=1.
- Armed; block high for 7 cycles, low for 1, then high for 7 -> rpt_valid never asserts; state returns to ARMED and the counter restarts at 1.
- Armed; proc_block=00110 with proc_idle=00010 for 8 cycles -> rpt_mask=00100, first_idx=2. Repeat with proc_block=00001 then 10001 -> rpt_mask=10001, first_idx=0.
- In REPORT, rpt_ready=0 for 5 cycles, then 1 -> fields stable throughout; rpt_valid drops one edge after ready; state LATCHED; deadlock stays 1.
- stop asserted on the same edge that would declare -> next state IDLE, rpt_valid=0, deadlock=0. start+stop together in IDLE -> remains IDLE.
- Reset asserted in LATCHED -> all outputs 0 on the next edge; a subsequent start re-arms normally. TIMEOUT=1 build: a single blocked cycle -> REPORT directly from ARMED.
